mmu_translate: RTL and testbench
================================

Name: mmu_translate

Overview:
Per-process address translation unit between the CPU fetch/decode stage and the dual-port block RAM. It fills the MMU stage of that pipeline: the stage hands it a process index and a 16-bit virtual address, and it returns a 10-bit physical RAM address or a fault. An internal page table holds 8 processes × 16 virtual pages. The table is cleared by an init sweep after reset and written through a config port.

Parameters:
PROC_BITS, 3, process index width (8 processes)
VPAGE_BITS, 4, virtual page number width (16 pages per process)
PAGE_BITS, 6, page offset width (64-word pages)
FRAME_BITS, 4, physical frame width; FRAME_BITS+PAGE_BITS must equal 10 (RAM address width)

Ports:
clka  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  translation request
req_ready  out  1  block can accept a request this cycle
req_proc  in  PROC_BITS  requesting process index
req_vaddr  in  16  virtual address
req_write  in  1  1 = access is a RAM write (reg2ram), 0 = read/fetch
rsp_valid  out  1  response valid, one-cycle pulse per accepted request
rsp_paddr  out  10  physical address (0 on fault)
rsp_fault  out  1  response is a fault
rsp_fault_code  out  2  0 none, 1 out of range, 2 page invalid, 3 write protect
fault_active  out  1  block is halted in FAULT state
fault_clr  in  1  leave FAULT state
cfg_we  in  1  page table write strobe
cfg_proc  in  PROC_BITS  entry process index
cfg_vpage  in  VPAGE_BITS  entry virtual page
cfg_valid  in  1  entry valid bit
cfg_writable  in  1  entry write-permission bit
cfg_frame  in  FRAME_BITS  entry physical frame
init_busy  out  1  init sweep in progress

Behaviour:
- Reset (async, any time, including mid-transaction): req_ready=0, rsp_valid=0, rsp_paddr=0, rsp_fault=0, rsp_fault_code=0, fault_active=0, init_busy=1. State = INIT, sweep counter = 0. Any in-flight request is dropped.
- The table holds 128 entries of {valid, writable, frame}, indexed by {proc, vpage}.
- INIT: clear one entry per cycle, counter 0..127. This takes 128 cycles after rst deasserts. req_ready=0 and cfg_we is ignored. After entry 127 is cleared: init_busy=0 and state = RUN.
- RUN: req_ready=1. A request is accepted when req_valid && req_ready.
- Latency is exactly 1. The response is registered and appears the cycle after acceptance. rsp_valid is held for one cycle only.
- Back-to-back requests on consecutive cycles give one response per cycle.
- Decode: vpage = vaddr[PAGE_BITS+VPAGE_BITS-1:PAGE_BITS]; offset = vaddr[PAGE_BITS-1:0].
- Fault priority, highest first:
  - code 1 if vaddr[15:PAGE_BITS+VPAGE_BITS] != 0;
  - else code 2 if the entry is not valid;
  - else code 3 if req_write and the entry is not writable.
- No fault: rsp_paddr = {frame, offset}, rsp_fault=0, code 0.
- Fault:
  - Response cycle: rsp_valid=1, rsp_fault=1, rsp_paddr=0, code set.
  - From the response cycle onward: state = FAULT, fault_active=1, req_ready=0.
- FAULT: hold until fault_clr is seen high at a clock edge. At that edge fault_active drops and state = RUN, so req_ready=1 from the next cycle. fault_clr is ignored in INIT and RUN.
- cfg_we is accepted in RUN and FAULT. The entry is updated at the clock edge.
- Same cycle, cfg_we and an accepted request to the same {proc, vpage}: the request uses the OLD entry contents. The new contents apply to requests accepted from the next cycle.
- Accepting a request never stalls for cfg traffic.
- Writes to a frame with an invalid entry are permitted; that frame simply cannot be reached until the entry is marked valid.

Test Plan:
- Pulse rst, release → req_ready=0 and init_busy=1 for exactly 128 cycles, then req_ready=1. Request proc 0, vaddr 0x0005 → next cycle rsp_valid=1, rsp_fault=1, code 2, paddr 0.
- cfg proc 2, vpage 3, valid=1, writable=0, frame 0xA. Read request proc 2, vaddr 0x00C7 → next cycle paddr 0x287, rsp_fault=0, code 0.
- Same entry, write request vaddr 0x00C7 → code 3, fault_active=1, req_ready=0 held for 5 cycles. Pulse fault_clr → req_ready=1 the following cycle.
- Request proc 1, vaddr 0x0400 → code 1, even when proc 1 vpage 0 is valid.
- Back-to-back reads proc 2: 0x00C0, 0x00FF, 0x00C1 → responses on 3 consecutive cycles: 0x280, 0x2BF, 0x281. In the cycle of the 0x00FF request, also apply cfg remapping vpage 3 to frame 0x1: the 0x00FF request still returns 0x2BF; the 0x00C1 request returns 0x041.
- rst asserted while a response is pending → rsp_valid stays 0, outputs are zero immediately, INIT repeats. A request to proc 2, vaddr 0x00C7 afterwards → code 2.

Source files
------------

// File: rtl/mmu_translate.sv
// Per-process virtual-to-physical translation for the block RAM port.
// Page table of {valid, writable, frame}, cleared by a sweep after reset, then 1-cycle lookups.
module mmu_translate #(
  parameter int PROC_BITS  = 3,
  parameter int VPAGE_BITS = 4,
  parameter int PAGE_BITS  = 6,
  parameter int FRAME_BITS = 4
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PROC_BITS-1:0]  req_proc,
  input  logic [15:0]           req_vaddr,
  input  logic                  req_write,
  output logic                  rsp_valid,
  output logic [9:0]            rsp_paddr,
  output logic                  rsp_fault,
  output logic [1:0]            rsp_fault_code,
  output logic                  fault_active,
  input  logic                  fault_clr,
  input  logic                  cfg_we,
  input  logic [PROC_BITS-1:0]  cfg_proc,
  input  logic [VPAGE_BITS-1:0] cfg_vpage,
  input  logic                  cfg_valid,
  input  logic                  cfg_writable,
  input  logic [FRAME_BITS-1:0] cfg_frame,
  output logic                  init_busy
);

  localparam int IDX_W   = PROC_BITS + VPAGE_BITS;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int ENT_W   = FRAME_BITS + 2;
  localparam int VA_HI   = PAGE_BITS + VPAGE_BITS;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_RANGE = 2'd1;
  localparam logic [1:0] FC_INVAL = 2'd2;
  localparam logic [1:0] FC_WPROT = 2'd3;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // Entry layout: {valid, writable, frame}
  logic [ENT_W-1:0] tbl_q [ENTRIES];

  logic             rsp_valid_q, rsp_valid_d;
  logic [9:0]       rsp_paddr_q, rsp_paddr_d;
  logic             rsp_fault_q, rsp_fault_d;
  logic [1:0]       rsp_code_q, rsp_code_d;

  logic             acc;
  logic [IDX_W-1:0] req_idx;
  logic [ENT_W-1:0] req_ent;
  logic [1:0]       code;

  logic             tbl_we;
  logic [IDX_W-1:0] tbl_widx;
  logic [ENT_W-1:0] tbl_wdata;

  // Lookup reads the current table contents, so a same-cycle cfg write is seen only next cycle
  always_comb begin
    acc     = req_valid && (state_q == ST_RUN);
    req_idx = {req_proc, req_vaddr[VA_HI-1:PAGE_BITS]};
    req_ent = tbl_q[req_idx];
    code    = FC_NONE;
    if (req_vaddr[15:VA_HI] != '0)
      code = FC_RANGE;
    else if (!req_ent[ENT_W-1])
      code = FC_INVAL;
    else if (req_write && !req_ent[ENT_W-2])
      code = FC_WPROT;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(ENTRIES - 1))
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (acc && code != FC_NONE)
          state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (fault_clr)
          state_d = ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    rsp_valid_d = acc;
    rsp_fault_d = acc && (code != FC_NONE);
    rsp_code_d  = acc ? code : FC_NONE;
    rsp_paddr_d = '0;
    if (acc && code == FC_NONE)
      rsp_paddr_d = {req_ent[FRAME_BITS-1:0], req_vaddr[PAGE_BITS-1:0]};
  end

  always_comb begin
    tbl_we    = 1'b0;
    tbl_widx  = cfg_idx_f(cfg_proc, cfg_vpage);
    tbl_wdata = {cfg_valid, cfg_writable, cfg_frame};
    if (state_q == ST_INIT) begin
      tbl_we    = 1'b1;
      tbl_widx  = cnt_q;
      tbl_wdata = '0;
    end else if (cfg_we) begin
      tbl_we = 1'b1;
    end
  end

  function automatic logic [IDX_W-1:0] cfg_idx_f(input logic [PROC_BITS-1:0] p,
                                                 input logic [VPAGE_BITS-1:0] v);
    return {p, v};
  endfunction

  // Control and response registers
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_paddr_q <= '0;
      rsp_fault_q <= 1'b0;
      rsp_code_q  <= FC_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_paddr_q <= rsp_paddr_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_code_q  <= rsp_code_d;
    end
  end

  // Table storage, cleared by the init sweep rather than by reset
  always_ff @(posedge clka) begin
    if (tbl_we)
      tbl_q[tbl_widx] <= tbl_wdata;
  end

  assign req_ready      = (state_q == ST_RUN);
  assign init_busy      = (state_q == ST_INIT);
  assign fault_active   = (state_q == ST_FAULT);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_paddr      = rsp_paddr_q;
  assign rsp_fault      = rsp_fault_q;
  assign rsp_fault_code = rsp_code_q;

endmodule

// File: tb/tb_mmu_translate.sv
// Directed bench for mmu_translate: init sweep, translation, faults, cfg ordering, reset mid-flight.
module tb_mmu_translate;

  logic       clka = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_proc;
  logic [15:0] req_vaddr;
  logic       req_write;
  logic       rsp_valid;
  logic [9:0] rsp_paddr;
  logic       rsp_fault;
  logic [1:0] rsp_fault_code;
  logic       fault_active;
  logic       fault_clr;
  logic       cfg_we;
  logic [2:0] cfg_proc;
  logic [3:0] cfg_vpage;
  logic       cfg_valid;
  logic       cfg_writable;
  logic [3:0] cfg_frame;
  logic       init_busy;

  int checks = 0;
  int errors = 0;
  int n;

  mmu_translate dut (
    .clka(clka), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_proc(req_proc),
    .req_vaddr(req_vaddr), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_paddr(rsp_paddr), .rsp_fault(rsp_fault),
    .rsp_fault_code(rsp_fault_code), .fault_active(fault_active), .fault_clr(fault_clr),
    .cfg_we(cfg_we), .cfg_proc(cfg_proc), .cfg_vpage(cfg_vpage), .cfg_valid(cfg_valid),
    .cfg_writable(cfg_writable), .cfg_frame(cfg_frame), .init_busy(init_busy)
  );

  always #5 clka = ~clka;

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [9:0] pa,
                         input logic f, input logic [1:0] c);
    chk({tag, ".valid"}, {15'd0, rsp_valid}, {15'd0, v});
    chk({tag, ".paddr"}, {6'd0, rsp_paddr}, {6'd0, pa});
    chk({tag, ".fault"}, {15'd0, rsp_fault}, {15'd0, f});
    chk({tag, ".code"}, {14'd0, rsp_fault_code}, {14'd0, c});
  endtask

  task automatic cfg_set(input logic [2:0] p, input logic [3:0] vp, input logic v,
                         input logic w, input logic [3:0] fr);
    cfg_we = 1'b1; cfg_proc = p; cfg_vpage = vp;
    cfg_valid = v; cfg_writable = w; cfg_frame = fr;
  endtask

  task automatic wait_init(input string tag);
    n = 0;
    while (req_ready !== 1'b1 && n < 300) begin
      chk({tag, ".busy"}, {15'd0, init_busy}, 16'd1);
      step();
      n++;
    end
    chk({tag, ".cycles"}, 16'(n), 16'd128);
    chk({tag, ".done"}, {15'd0, init_busy}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_proc = '0; req_vaddr = '0; req_write = 1'b0;
    fault_clr = 1'b0; cfg_we = 1'b0; cfg_proc = '0; cfg_vpage = '0;
    cfg_valid = 1'b0; cfg_writable = 1'b0; cfg_frame = '0;
    step(); step();
    chk("rst.ready", {15'd0, req_ready}, 16'd0);
    chk("rst.busy", {15'd0, init_busy}, 16'd1);
    chk("rst.factive", {15'd0, fault_active}, 16'd0);
    chk_rsp("rst.rsp", 1'b0, 10'h0, 1'b0, 2'd0);
    rst = 1'b0;

    wait_init("init1");

    // Cleared table: any lookup faults as invalid
    req_valid = 1'b1; req_proc = 3'd0; req_vaddr = 16'h0005; req_write = 1'b0;
    step();
    req_valid = 1'b0;
    chk_rsp("inval", 1'b1, 10'h0, 1'b1, 2'd2);
    chk("inval.factive", {15'd0, fault_active}, 16'd1);
    chk("inval.ready", {15'd0, req_ready}, 16'd0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr1.factive", {15'd0, fault_active}, 16'd0);
    chk("clr1.ready", {15'd0, req_ready}, 16'd1);
    chk("clr1.pulse", {15'd0, rsp_valid}, 16'd0);

    cfg_set(3'd2, 4'd3, 1'b1, 1'b0, 4'hA);
    step();
    cfg_we = 1'b0;
    req_valid = 1'b1; req_proc = 3'd2; req_vaddr = 16'h00C7; req_write = 1'b0;
    step();
    req_valid = 1'b0;
    chk_rsp("read", 1'b1, 10'h287, 1'b0, 2'd0);
    chk("read.factive", {15'd0, fault_active}, 16'd0);

    req_valid = 1'b1; req_write = 1'b1;
    step();
    req_valid = 1'b0; req_write = 1'b0;
    chk_rsp("wprot", 1'b1, 10'h0, 1'b1, 2'd3);
    chk("wprot.factive", {15'd0, fault_active}, 16'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wprot.hold", {15'd0, req_ready}, 16'd0);
    end
    chk("wprot.pulse", {15'd0, rsp_valid}, 16'd0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr2.ready", {15'd0, req_ready}, 16'd1);

    // Out-of-range wins over a valid entry
    cfg_set(3'd1, 4'd0, 1'b1, 1'b1, 4'h3);
    step();
    cfg_we = 1'b0;
    req_valid = 1'b1; req_proc = 3'd1; req_vaddr = 16'h0400;
    step();
    req_valid = 1'b0;
    chk_rsp("range", 1'b1, 10'h0, 1'b1, 2'd1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    req_valid = 1'b1; req_proc = 3'd1; req_vaddr = 16'h0010; req_write = 1'b1;
    step();
    req_valid = 1'b0; req_write = 1'b0;
    chk_rsp("wok", 1'b1, 10'h0D0, 1'b0, 2'd0);
    chk("wok.ready", {15'd0, req_ready}, 16'd1);

    // Back-to-back with a remap landing alongside the middle request
    req_valid = 1'b1; req_proc = 3'd2; req_vaddr = 16'h00C0;
    step();
    chk_rsp("b2b0", 1'b1, 10'h280, 1'b0, 2'd0);
    req_vaddr = 16'h00FF;
    cfg_set(3'd2, 4'd3, 1'b1, 1'b0, 4'h1);
    step();
    cfg_we = 1'b0;
    chk_rsp("b2b1", 1'b1, 10'h2BF, 1'b0, 2'd0);
    req_vaddr = 16'h00C1;
    step();
    req_valid = 1'b0;
    chk_rsp("b2b2", 1'b1, 10'h041, 1'b0, 2'd0);
    step();
    chk("b2b.idle", {15'd0, rsp_valid}, 16'd0);

    // Reset while a response is pending
    req_valid = 1'b1; req_proc = 3'd2; req_vaddr = 16'h00C7; req_write = 1'b0;
    #3;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk_rsp("rstmid.now", 1'b0, 10'h0, 1'b0, 2'd0);
    chk("rstmid.ready", {15'd0, req_ready}, 16'd0);
    chk("rstmid.busy", {15'd0, init_busy}, 16'd1);
    step();
    chk_rsp("rstmid.edge", 1'b0, 10'h0, 1'b0, 2'd0);
    rst = 1'b0;
    wait_init("init2");
    req_valid = 1'b1; req_proc = 3'd2; req_vaddr = 16'h00C7;
    step();
    req_valid = 1'b0;
    chk_rsp("post", 1'b1, 10'h0, 1'b1, 2'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
